ps2_keys_rx: RTL
================

PS2_KEYS_RX -- requirements
Module: ps2_keys_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the CLOCK_50 cycles without a PS/2 falling edge that abort a partial frame (1 ms).
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning the consecutive equal synchronized samples required to accept a PS2_CLK level change.
REQ-003 SHALL have port CLOCK_50  input  1  system clock, 50 MHz; the block's only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port PS2_CLK  input  1  keyboard clock, asynchronous to CLOCK_50.
REQ-006 SHALL have port PS2_DAT  input  1  keyboard data, asynchronous to CLOCK_50.
REQ-007 SHALL have port keysout  output  4  held-key levels, 1 = held: [0] left (E0 6B), [1] right (E0 74), [2] space (29, fire), [3] enter (5A).
REQ-008 SHALL have port scan_code  output  8  last correctly received byte.
REQ-009 SHALL have port code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass PS2_CLK and PS2_DAT through two-flop synchronizers before any use.
REQ-012 SHALL accept a PS2_CLK level change only after FILTER_LEN consecutive equal synchronized samples, and SHALL detect a falling edge on the filtered clock.
REQ-013 SHALL sample synchronized PS2_DAT on each detected falling edge.
REQ-014 SHALL implement FSM IDLE -> DATA -> PARITY -> STOP -> IDLE.
REQ-015 IDLE: on an edge with data 0, go to DATA with the bit counter at 0; on an edge with data 1, stay in IDLE (false start, no error).
REQ-016 DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
REQ-017 PARITY: the parity bit plus the 8 data bits SHALL have an odd count of ones; record pass/fail; go to STOP.
REQ-018 STOP: on the edge, if stop bit = 1 and parity passed, load scan_code and pulse code_valid on the next cycle; otherwise pulse frame_err; always return to IDLE.
REQ-019 In any state other than IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL force IDLE and pulse frame_err; the idle counter restarts on every edge.
REQ-020 The decoder SHALL act only on code_valid:
- E0 sets ext.
- F0 sets brk.
- Any other byte: if {ext, byte} matches a mapped key, set that keysout bit to NOT brk; then clear ext and brk.
REQ-021 Unmapped codes SHALL leave keysout unchanged and clear ext and brk.
REQ-022 keysout SHALL update in the same cycle code_valid is high.
REQ-023 A frame error SHALL clear ext and brk and leave keysout unchanged.
REQ-024 Multiple keys SHALL be held simultaneously and independently.
REQ-025 Repeated make codes (typematic) SHALL leave an already-set bit at 1.

Reset
REQ-026 While reset = 0: FSM in IDLE; counters, shift register, ext and brk cleared; keysout = 0, scan_code = 00, code_valid = 0, frame_err = 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame.
REQ-028 After reset deasserts, the block SHALL start in IDLE, and an in-progress keyboard frame SHALL be treated as noise until a valid start bit.

Structure
REQ-029 Scan-code constants (E0, F0, 6B, 74, 29, 5A), the keysout bit indices and the FSM state encoding SHALL live in a shared package.
REQ-030 The frame receiver (REQ-011 to REQ-019) SHALL be sub-module ps2_frame_rx, outputting byte, valid and err; ps2_keys_rx SHALL hold only the decoder and the keysout register.
REQ-031 The block SHALL fit 120-400 RTL lines with no memories.

Verification
REQ-032 Send frame 29 (odd parity bit 0, stop 1) at 12.5 kHz -> code_valid pulses once, scan_code = 29, keysout = 0100.
REQ-033 Send E0 74, then E0 F0 74 -> keysout[1] goes to 1 after the second byte and returns to 0 after the fifth; other bits stay 0.
REQ-034 Send 5A with the parity bit inverted -> frame_err pulses once, no code_valid, keysout unchanged; a following correct 5A sets keysout[3].
REQ-035 Send a start bit plus 4 data bits, then idle 1.2 ms -> frame_err pulses once, FSM back in IDLE; a following full frame 29 decodes correctly.
REQ-036 Hold space and left (29, E0 6B), then F0 29 -> keysout goes 0100, then 0101, then 0001.
REQ-037 Assert reset during the data bits of frame 5A -> all outputs 0; no code_valid after release until the next complete frame.

Source files
------------

// File: rtl/ps2_keys_rx_pkg.sv
// Shared constants for the PS/2 key receiver: scan codes, keysout bit indices,
// frame FSM encoding and the {ext, code} -> key lookup.
package ps2_keys_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;
    localparam logic [7:0] CodeSpace = 8'h29;
    localparam logic [7:0] CodeEnter = 8'h5A;

    localparam int unsigned NumKeys  = 4;
    localparam int unsigned KeyLeft  = 0;
    localparam int unsigned KeyRight = 1;
    localparam int unsigned KeySpace = 2;
    localparam int unsigned KeyEnter = 3;

    // One-hot keysout mask for a completed code; all zeros when unmapped.
    function automatic logic [NumKeys-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NumKeys-1:0] mask;
        mask = '0;
        if (ext && code == CodeLeft)   mask[KeyLeft]  = 1'b1;
        if (ext && code == CodeRight)  mask[KeyRight] = 1'b1;
        if (!ext && code == CodeSpace) mask[KeySpace] = 1'b1;
        if (!ext && code == CodeEnter) mask[KeyEnter] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and deglitches the keyboard clock, shifts in
// start/8 data/parity/stop and reports each byte or frame error as a pulse.
module ps2_frame_rx
    import ps2_keys_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_byte,
    output logic       valid,
    output logic       err
);

    localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall_q, dat_q;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [ToW-1:0]   idle_cnt_q, idle_cnt_d;
    logic             timeout;

    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       byte_q, byte_d;

    // Lines idle high, so sync and filter reset high to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            dat_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= clk_filt_q & ~clk_filt_d;
            dat_q      <= dat_sync_q[1];
        end
    end

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        idle_cnt_d = '0;
        timeout    = 1'b0;

        if (state_q != StIdle && !fall_q) begin
            if (idle_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + ToW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (fall_q && !dat_q) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                end
            end
            StData: begin
                if (fall_q) begin
                    shift_d   = {dat_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (fall_q) begin
                    par_ok_d = ^{dat_q, shift_q};
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall_q) state_d = StIdle;
            end
        endcase

        if (timeout) state_d = StIdle;
    end

    always_comb begin
        valid_d = (state_q == StStop) && fall_q && dat_q && par_ok_q;
        err_d   = ((state_q == StStop) && fall_q && !(dat_q && par_ok_q)) || timeout;
        byte_d  = valid_d ? shift_q : byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_ok_q   <= 1'b0;
            idle_cnt_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            idle_cnt_q <= idle_cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            byte_q     <= byte_d;
        end
    end

    assign data_byte = byte_q;
    assign valid     = valid_q;
    assign err       = err_q;

endmodule

// File: rtl/ps2_keys_rx.sv
// PS/2 keyboard front end: frame receiver plus make/break decoder that tracks
// the held state of left, right, space and enter.
module ps2_keys_rx
    import ps2_keys_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [3:0] keysout,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [NumKeys-1:0] keys_q, keys_d, hit;
    logic               ext_q, ext_d;
    logic               brk_q, brk_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_frame_rx (
        .clk      (CLOCK_50),
        .rst_n    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .data_byte(scan_code),
        .valid    (code_valid),
        .err      (frame_err)
    );

    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        hit    = key_mask(ext_q, scan_code);
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (code_valid) begin
            if (scan_code == CodeExt) begin
                ext_d = 1'b1;
            end else if (scan_code == CodeBrk) begin
                brk_d = 1'b1;
            end else begin
                keys_d = brk_q ? (keys_q & ~hit) : (keys_q | hit);
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            keys_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            keys_q <= keys_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    // Driven from the next-state value so a decoded key is visible during code_valid.
    assign keysout = keys_d;

endmodule
